// File: rtl/cc_lane_shifter.sv
// rtl/cc_lane_shifter.sv - five obstacle lanes, seeded on load and rotated at a level-dependent rate
// Optional LANESHIFTER_PARALLEL_LOAD_EN replaces the parameter seeds with a run-time seed bus.
module cc_lane_shifter #(
   parameter int LANESHIFTER_DATAWIDTH   = 8,
   parameter int LANESHIFTER_CNTWIDTH    = 24,
   parameter int LANESHIFTER_BASE_PERIOD = 12500000,
   parameter logic [LANESHIFTER_DATAWIDTH-1:0] LANESHIFTER_SEED4 = 8'h03,
   parameter logic [LANESHIFTER_DATAWIDTH-1:0] LANESHIFTER_SEED3 = 8'h18,
   parameter logic [LANESHIFTER_DATAWIDTH-1:0] LANESHIFTER_SEED2 = 8'hC0,
   parameter logic [LANESHIFTER_DATAWIDTH-1:0] LANESHIFTER_SEED1 = 8'h06,
   parameter logic [LANESHIFTER_DATAWIDTH-1:0] LANESHIFTER_SEED0 = 8'h81
) (
   input  logic                               CC_LANESHIFTER_CLOCK_50,
   input  logic                               CC_LANESHIFTER_RESET_InLow,
   input  logic                               CC_LANESHIFTER_clear_InHigh,
   input  logic                               CC_LANESHIFTER_load_InHigh,
   input  logic                               CC_LANESHIFTER_enable_InHigh,
   input  logic [1:0]                         CC_LANESHIFTER_level_InBUS,
`ifdef LANESHIFTER_PARALLEL_LOAD_EN
   input  logic [5*LANESHIFTER_DATAWIDTH-1:0] CC_LANESHIFTER_seed_InBUS,
`endif
   output logic [LANESHIFTER_DATAWIDTH-1:0]   CC_LANESHIFTER_registro4_OutBUS,
   output logic [LANESHIFTER_DATAWIDTH-1:0]   CC_LANESHIFTER_registro3_OutBUS,
   output logic [LANESHIFTER_DATAWIDTH-1:0]   CC_LANESHIFTER_registro2_OutBUS,
   output logic [LANESHIFTER_DATAWIDTH-1:0]   CC_LANESHIFTER_registro1_OutBUS,
   output logic [LANESHIFTER_DATAWIDTH-1:0]   CC_LANESHIFTER_registro0_OutBUS,
   output logic                               CC_LANESHIFTER_tick_OutHigh,
   output logic [1:0]                         CC_LANESHIFTER_state_OutBUS
);

   localparam int DW = LANESHIFTER_DATAWIDTH;
   localparam int CW = LANESHIFTER_CNTWIDTH;
   localparam logic [CW-1:0] BASE = CW'(LANESHIFTER_BASE_PERIOD);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [4:0][DW-1:0]    lanes_q, lanes_d;
   logic [4:0][DW-1:0]    seeds;
   logic [CW-1:0]         presc_q, presc_d;
   logic                  phase_q, phase_d;
   logic                  tick_q, tick_d;
   logic [CW-1:0]         limit_m1;
   logic                  wrap;

`ifdef LANESHIFTER_PARALLEL_LOAD_EN
   assign seeds = CC_LANESHIFTER_seed_InBUS;
`else
   assign seeds = {LANESHIFTER_SEED4, LANESHIFTER_SEED3, LANESHIFTER_SEED2,
                   LANESHIFTER_SEED1, LANESHIFTER_SEED0};
`endif

   // >= rather than == so that raising the level mid-count wraps immediately
   assign limit_m1 = (BASE >> CC_LANESHIFTER_level_InBUS) - CW'(1);
   assign wrap     = (presc_q >= limit_m1);

   function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x);
      return {x[DW-2:0], x[DW-1]};
   endfunction

   function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x);
      return {x[0], x[DW-1:1]};
   endfunction

   always_comb begin
      state_d = state_q;
      lanes_d = lanes_q;
      presc_d = presc_q;
      phase_d = phase_q;
      tick_d  = 1'b0;
      if (CC_LANESHIFTER_clear_InHigh) begin
         state_d = IDLE;
         lanes_d = '0;
         presc_d = '0;
         phase_d = 1'b0;
      end else if (CC_LANESHIFTER_load_InHigh) begin
         lanes_d = seeds;
         presc_d = '0;
         phase_d = 1'b0;
         state_d = CC_LANESHIFTER_enable_InHigh ? RUN : PAUSE;
      end else begin
         case (state_q)
            IDLE: ;
            RUN: begin
               if (!CC_LANESHIFTER_enable_InHigh) begin
                  state_d = PAUSE;
               end else if (wrap) begin
                  presc_d    = '0;
                  tick_d     = 1'b1;
                  phase_d    = ~phase_q;
                  lanes_d[4] = rotl(lanes_q[4]);
                  lanes_d[2] = rotl(lanes_q[2]);
                  lanes_d[0] = rotl(lanes_q[0]);
                  // odd lanes move at half rate: every second tick since load
                  if (phase_q) begin
                     lanes_d[3] = rotr(lanes_q[3]);
                     lanes_d[1] = rotr(lanes_q[1]);
                  end
               end else begin
                  presc_d = presc_q + CW'(1);
               end
            end
            PAUSE: begin
               if (CC_LANESHIFTER_enable_InHigh) state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CC_LANESHIFTER_CLOCK_50) begin
      if (!CC_LANESHIFTER_RESET_InLow) begin
         state_q <= IDLE;
         lanes_q <= '0;
         presc_q <= '0;
         phase_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lanes_q <= lanes_d;
         presc_q <= presc_d;
         phase_q <= phase_d;
         tick_q  <= tick_d;
      end
   end

   assign CC_LANESHIFTER_registro4_OutBUS = lanes_q[4];
   assign CC_LANESHIFTER_registro3_OutBUS = lanes_q[3];
   assign CC_LANESHIFTER_registro2_OutBUS = lanes_q[2];
   assign CC_LANESHIFTER_registro1_OutBUS = lanes_q[1];
   assign CC_LANESHIFTER_registro0_OutBUS = lanes_q[0];
   assign CC_LANESHIFTER_tick_OutHigh     = tick_q;
   assign CC_LANESHIFTER_state_OutBUS     = state_q;

endmodule

// File: tb/tb_cc_lane_shifter.sv
// tb/tb_cc_lane_shifter.sv - directed self-checking bench for cc_lane_shifter (BASE_PERIOD=8)
module tb_cc_lane_shifter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  level = 2'd0;
`ifdef LANESHIFTER_PARALLEL_LOAD_EN
   logic [39:0] seed_bus = 40'h0;
`endif
   logic [7:0]  r4, r3, r2, r1, r0;
   logic        tick;
   logic [1:0]  state;
   logic [39:0] lanes;
   int          checks = 0;
   int          errors = 0;

   localparam logic [39:0] SEEDS = 40'h03_18_C0_06_81;

   assign lanes = {r4, r3, r2, r1, r0};

   always #5 clk = ~clk;

   cc_lane_shifter #(.LANESHIFTER_BASE_PERIOD(8)) dut (
      .CC_LANESHIFTER_CLOCK_50        (clk),
      .CC_LANESHIFTER_RESET_InLow     (resetn),
      .CC_LANESHIFTER_clear_InHigh    (clear),
      .CC_LANESHIFTER_load_InHigh     (load),
      .CC_LANESHIFTER_enable_InHigh   (enable),
      .CC_LANESHIFTER_level_InBUS     (level),
`ifdef LANESHIFTER_PARALLEL_LOAD_EN
      .CC_LANESHIFTER_seed_InBUS      (seed_bus),
`endif
      .CC_LANESHIFTER_registro4_OutBUS(r4),
      .CC_LANESHIFTER_registro3_OutBUS(r3),
      .CC_LANESHIFTER_registro2_OutBUS(r2),
      .CC_LANESHIFTER_registro1_OutBUS(r1),
      .CC_LANESHIFTER_registro0_OutBUS(r0),
      .CC_LANESHIFTER_tick_OutHigh    (tick),
      .CC_LANESHIFTER_state_OutBUS    (state)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic en);
      enable = en;
      load = 1'b1;
      step(1);
      load = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0; load = 1'b1; enable = 1'b1;
      step(2);
      checks++; if (lanes !== 40'h0) begin errors++; $display("FAIL reset_lanes got %h want %h", lanes, 40'h0); end
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
      load = 1'b0; enable = 1'b0;
      resetn = 1'b1;
      step(2);
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b want 00", state); end
   endtask

   task automatic test_load_run;
      level = 2'd0;
      do_load(1'b1);
      checks++; if (lanes !== SEEDS) begin errors++; $display("FAIL load_lanes got %h want %h", lanes, SEEDS); end
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL load_state got %b want 01", state); end
      step(7);
      checks++; if (tick !== 1'b0 || lanes !== SEEDS) begin errors++; $display("FAIL early_tick got tick=%b lanes=%h want tick=0 lanes=%h", tick, lanes, SEEDS); end
      step(1);
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b want 1", tick); end
      checks++; if (lanes !== 40'h06_18_81_06_03) begin errors++; $display("FAIL first_shift got %h want %h", lanes, 40'h06_18_81_06_03); end
      step(1);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_one_cycle got %b want 0", tick); end
      step(7);
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL second_tick got %b want 1", tick); end
      checks++; if (lanes !== 40'h0C_0C_03_03_06) begin errors++; $display("FAIL second_shift got %h want %h", lanes, 40'h0C_0C_03_03_06); end
   endtask

   task automatic test_level;
      level = 2'd1;
      do_load(1'b1);
      step(3);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL lvl1_early got %b want 0", tick); end
      step(1);
      checks++; if (tick !== 1'b1 || r4 !== 8'h06) begin errors++; $display("FAIL lvl1_tick1 got tick=%b r4=%h want 1/06", tick, r4); end
      step(4);
      checks++; if (tick !== 1'b1 || r4 !== 8'h0C) begin errors++; $display("FAIL lvl1_tick2 got tick=%b r4=%h want 1/0C", tick, r4); end
      step(3);
      level = 2'd2;
      step(1);
      checks++; if (tick !== 1'b1 || r4 !== 8'h18) begin errors++; $display("FAIL lvl_drop_wrap got tick=%b r4=%h want 1/18", tick, r4); end
      step(1);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL lvl2_gap got %b want 0", tick); end
      step(1);
      checks++; if (tick !== 1'b1 || r4 !== 8'h30) begin errors++; $display("FAIL lvl2_tick got tick=%b r4=%h want 1/30", tick, r4); end
      level = 2'd3;
      step(1);
      checks++; if (tick !== 1'b1 || r4 !== 8'h60) begin errors++; $display("FAIL lvl3_tick1 got tick=%b r4=%h want 1/60", tick, r4); end
      step(1);
      checks++; if (tick !== 1'b1 || r4 !== 8'hC0) begin errors++; $display("FAIL lvl3_tick2 got tick=%b r4=%h want 1/C0", tick, r4); end
      checks++; if (r3 !== 8'h03) begin errors++; $display("FAIL lvl_odd_lane got %h want 03", r3); end
      level = 2'd0;
   endtask

   task automatic test_pause;
      do_load(1'b1);
      step(5);
      enable = 1'b0;
      step(1);
      checks++; if (state !== 2'b10 || tick !== 1'b0) begin errors++; $display("FAIL pause_enter got state=%b tick=%b want 10/0", state, tick); end
      step(9);
      checks++; if (state !== 2'b10 || lanes !== SEEDS || tick !== 1'b0) begin errors++; $display("FAIL pause_hold got state=%b lanes=%h tick=%b want 10/%h/0", state, lanes, tick, SEEDS); end
      enable = 1'b1;
      step(1);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL pause_resume got %b want 01", state); end
      step(2);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL resume_early got %b want 0", tick); end
      step(1);
      checks++; if (tick !== 1'b1 || r4 !== 8'h06) begin errors++; $display("FAIL resume_tick got tick=%b r4=%h want 1/06", tick, r4); end
   endtask

   task automatic test_priority;
      clear = 1'b1; load = 1'b1;
      step(1);
      clear = 1'b0; load = 1'b0;
      checks++; if (lanes !== 40'h0 || state !== 2'b00 || tick !== 1'b0) begin errors++; $display("FAIL clear_over_load got lanes=%h state=%b tick=%b want 0/00/0", lanes, state, tick); end
      step(3);
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_ignores_enable got %b want 00", state); end
      do_load(1'b1);
      step(6);
      do_load(1'b1);
      checks++; if (lanes !== SEEDS) begin errors++; $display("FAIL reload_lanes got %h want %h", lanes, SEEDS); end
      step(7);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reload_restart got %b want 0", tick); end
      step(1);
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL reload_tick got %b want 1", tick); end
      load = 1'b1;
      step(12);
      checks++; if (lanes !== SEEDS || tick !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL load_held got lanes=%h tick=%b state=%b want %h/0/01", lanes, tick, state, SEEDS); end
      load = 1'b0;
      do_load(1'b0);
      checks++; if (state !== 2'b10) begin errors++; $display("FAIL load_no_enable got %b want 10", state); end
   endtask

`ifdef LANESHIFTER_PARALLEL_LOAD_EN
   task automatic test_parallel_load;
      seed_bus = 40'h0102040810;
      do_load(1'b1);
      checks++; if (lanes !== 40'h0102040810) begin errors++; $display("FAIL parallel_load got %h want %h", lanes, 40'h0102040810); end
   endtask
`endif

   initial begin
      test_reset();
      test_load_run();
      test_level();
      test_pause();
      test_priority();
`ifdef LANESHIFTER_PARALLEL_LOAD_EN
      test_parallel_load();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
